// File: rtl/tick_scheduler.sv
// Shared timebase: one prescaler tick enable plus four one-shot/periodic channel timers
// driven through a two-state valid/ready config port.
module tick_scheduler #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 1000,
  parameter int unsigned PW      = 16
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [1:0]    cfg_chan,
  input  logic [1:0]    cfg_cmd,
  input  logic [PW-1:0] cfg_period,
  output logic          tick,
  output logic [3:0]    active,
  output logic [3:0]    expire
);

  localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned CW    = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int unsigned NCH   = 4;

  localparam logic [1:0] CMD_STOP    = 2'b00;
  localparam logic [1:0] CMD_ONESHOT = 2'b01;
  localparam logic [1:0] CMD_PERIOD  = 2'b10;
  localparam logic [1:0] CMD_RESTART = 2'b11;

  typedef enum logic {CFG_READY, CFG_COMMIT} cfg_state_t;
  typedef enum logic {CH_IDLE, CH_RUN} ch_state_t;

  logic [CW-1:0] count;
  cfg_state_t    cfg_state;
  logic [1:0]    lat_chan;
  logic [1:0]    lat_cmd;
  logic [PW-1:0] lat_period;
  logic          commit_c;

  ch_state_t     ch_state  [NCH];
  logic [PW-1:0] remaining [NCH];
  logic [PW-1:0] period    [NCH];
  logic          periodic  [NCH];

  // Free-running prescaler; tick is registered one cycle after the terminal count
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= (count == CW'(DIV - 1));
      if (count == CW'(DIV - 1)) begin
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

  // Config FSM: accept in READY, apply on the following edge from COMMIT
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cfg_state  <= CFG_READY;
      cfg_ready  <= 1'b0;
      lat_chan   <= '0;
      lat_cmd    <= '0;
      lat_period <= '0;
    end else begin
      case (cfg_state)
        CFG_READY: begin
          cfg_ready <= 1'b1;
          if (cfg_valid && cfg_ready) begin
            lat_chan   <= cfg_chan;
            lat_cmd    <= cfg_cmd;
            lat_period <= cfg_period;
            cfg_state  <= CFG_COMMIT;
            cfg_ready  <= 1'b0;
          end
        end
        CFG_COMMIT: begin
          cfg_state <= CFG_READY;
          cfg_ready <= 1'b1;
        end
        default: begin
          cfg_state <= CFG_READY;
          cfg_ready <= 1'b0;
        end
      endcase
    end
  end

  assign commit_c = (cfg_state == CFG_COMMIT);

  // Channel timers; a commit to a channel overrides any tick that channel would see
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      active <= '0;
      expire <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        ch_state[i]  <= CH_IDLE;
        remaining[i] <= '0;
        period[i]    <= '0;
        periodic[i]  <= 1'b0;
      end
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        expire[i] <= 1'b0;
        if (commit_c && (lat_chan == 2'(i))) begin
          case (lat_cmd)
            CMD_ONESHOT, CMD_PERIOD: begin
              if (lat_period == '0) begin
                ch_state[i] <= CH_IDLE;
                active[i]   <= 1'b0;
              end else begin
                period[i]    <= lat_period;
                remaining[i] <= lat_period;
                periodic[i]  <= (lat_cmd == CMD_PERIOD);
                ch_state[i]  <= CH_RUN;
                active[i]    <= 1'b1;
              end
            end
            CMD_RESTART: begin
              if (ch_state[i] == CH_RUN) begin
                remaining[i] <= period[i];
              end
            end
            default: begin
              ch_state[i] <= CH_IDLE;
              active[i]   <= 1'b0;
            end
          endcase
        end else if ((ch_state[i] == CH_RUN) && tick) begin
          if (remaining[i] <= PW'(1)) begin
            expire[i] <= 1'b1;
            if (periodic[i]) begin
              remaining[i] <= period[i];
            end else begin
              ch_state[i] <= CH_IDLE;
              active[i]   <= 1'b0;
            end
          end else begin
            remaining[i] <= remaining[i] - PW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler with an expiry scoreboard keyed on clock index.
module tb_tick_scheduler;

  localparam int unsigned PW  = 16;
  localparam int unsigned DIV = 10;

  localparam logic [1:0] CMD_STOP    = 2'b00;
  localparam logic [1:0] CMD_ONESHOT = 2'b01;
  localparam logic [1:0] CMD_PERIOD  = 2'b10;
  localparam logic [1:0] CMD_RESTART = 2'b11;

  logic          clk_in = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [1:0]    cfg_chan;
  logic [1:0]    cfg_cmd;
  logic [PW-1:0] cfg_period;
  logic          tick;
  logic [3:0]    active;
  logic [3:0]    expire;

  tick_scheduler #(.CLK_HZ(20), .TICK_HZ(2), .PW(PW)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_cmd   (cfg_cmd),
    .cfg_period(cfg_period),
    .tick      (tick),
    .active    (active),
    .expire    (expire)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  mask;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned cyc;

  // Clock index: number of rising edges since reset release
  always @(posedge clk_in or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Edge on which the p-th tick after commit edge c is consumed; expire is visible after it
  function automatic int unsigned nth_tick(input int unsigned c, input int unsigned p);
    int unsigned e;
    e = c + 1;
    while ((e % DIV) != 1) e++;
    return e + (p - 1) * DIV;
  endfunction

  task automatic push_exp(input int unsigned c, input logic [3:0] m);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (exp_q[k].cyc == c) begin
        exp_q[k].mask = exp_q[k].mask | m;
        return;
      end
      if (exp_q[k].cyc > c) begin
        exp_q.insert(k, '{c, m});
        return;
      end
    end
    exp_q.push_back('{c, m});
  endtask

  // Monitor: tick cadence every cycle, expire pulses against the scoreboard
  always @(negedge clk_in) begin
    if (rst === 1'b0) begin
      check("tick", 32'(tick), 32'((cyc != 0) && ((cyc % DIV) == 0)));
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        check("expire_missed_cyc", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (expire !== 4'b0000) begin
        if (exp_q.size() == 0) begin
          check("expire_unexpected", 32'(expire), 32'(0));
        end else begin
          check("expire_cyc", cyc, exp_q[0].cyc);
          if (exp_q[0].cyc == cyc) begin
            check("expire_mask", 32'(expire), 32'(exp_q[0].mask));
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic wait_until(input int unsigned target);
    while (cyc < target) @(negedge clk_in);
  endtask

  // Present one request at a negedge; returns the edge on which it is applied
  task automatic issue(input logic [1:0] ch, input logic [1:0] cmd,
                       input logic [PW-1:0] per, output int unsigned commit_cyc);
    int unsigned n;
    n = 0;
    while (!cfg_ready && n < 10) begin
      @(negedge clk_in);
      n++;
    end
    if (!cfg_ready) check("cfg_ready_timeout", 32'(cfg_ready), 32'(1));
    cfg_valid  = 1'b1;
    cfg_chan   = ch;
    cfg_cmd    = cmd;
    cfg_period = per;
    @(negedge clk_in);
    cfg_valid  = 1'b0;
    commit_cyc = cyc + 1;
  endtask

  initial begin
    int unsigned c;
    int unsigned e;
    int unsigned r;
    int unsigned s;
    int unsigned acc;

    rst        = 1'b1;
    cfg_valid  = 1'b0;
    cfg_chan   = '0;
    cfg_cmd    = '0;
    cfg_period = '0;

    // Reset state
    repeat (3) @(negedge clk_in);
    check("rst_tick", 32'(tick), 32'(0));
    check("rst_active", 32'(active), 32'(0));
    check("rst_expire", 32'(expire), 32'(0));
    check("rst_cfg_ready", 32'(cfg_ready), 32'(0));
    #2 rst = 1'b0;
    #1 check("ready_at_release", 32'(cfg_ready), 32'(0));
    @(negedge clk_in);
    check("ready_after_edge1", 32'(cfg_ready), 32'(1));
    wait_until(31);

    // One-shot ch0, period 3
    issue(2'd0, CMD_ONESHOT, PW'(3), c);
    e = nth_tick(c, 3);
    push_exp(e, 4'b0001);
    @(negedge clk_in);
    check("oneshot_active", 32'(active[0]), 32'(1));
    wait_until(e - 1);
    check("oneshot_active_before", 32'(active[0]), 32'(1));
    wait_until(e);
    check("oneshot_active_fall", 32'(active[0]), 32'(0));
    wait_until(e + 100);

    // Periodic ch1, period 2, then stop mid-count
    issue(2'd1, CMD_PERIOD, PW'(2), c);
    e = nth_tick(c, 2);
    push_exp(e, 4'b0010);
    push_exp(e + 2 * DIV, 4'b0010);
    push_exp(e + 4 * DIV, 4'b0010);
    wait_until(e + 44);
    check("periodic_active", 32'(active[1]), 32'(1));
    issue(2'd1, CMD_STOP, PW'(0), s);
    @(negedge clk_in);
    check("stop_active", 32'(active[1]), 32'(0));
    wait_until(s + 80);

    // Back-to-back requests: accepts on alternate clocks only
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      cfg_valid  = 1'b1;
      cfg_chan   = 2'(i);
      cfg_cmd    = CMD_ONESHOT;
      cfg_period = PW'(50);
      check("ready_toggle", 32'(cfg_ready), 32'((i % 2) == 0));
      if (cfg_ready) acc++;
      @(negedge clk_in);
    end
    cfg_valid = 1'b0;
    check("accept_count", acc, 32'(3));
    check("accept_chans", 32'(active), 32'(4'b0101));
    issue(2'd0, CMD_STOP, PW'(0), c);
    issue(2'd2, CMD_STOP, PW'(0), c);
    @(negedge clk_in);
    check("stop_both", 32'(active), 32'(0));

    // Restart committed on the tick where remaining==1 suppresses that expiry
    issue(2'd2, CMD_ONESHOT, PW'(4), c);
    e = nth_tick(c, 4);
    wait_until(e - 2);
    issue(2'd2, CMD_RESTART, PW'(0), r);
    check("restart_commit_edge", r, e);
    push_exp(nth_tick(r, 4), 4'b0100);
    @(negedge clk_in);
    check("restart_active", 32'(active[2]), 32'(1));
    wait_until(nth_tick(r, 4) + 1);
    check("restart_oneshot_done", 32'(active[2]), 32'(0));

    // All channels running, then asynchronous reset on a tick cycle
    for (int i = 0; i < 4; i++) issue(2'(i), CMD_PERIOD, PW'(100), c);
    @(negedge clk_in);
    check("all_active", 32'(active), 32'(4'hf));
    wait_until(((cyc / DIV) + 1) * DIV);
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    #2 rst = 1'b1;
    #1;
    check("async_rst_active", 32'(active), 32'(0));
    check("async_rst_expire", 32'(expire), 32'(0));
    check("async_rst_tick", 32'(tick), 32'(0));
    check("async_rst_ready", 32'(cfg_ready), 32'(0));
    exp_q.delete();
    repeat (2) @(negedge clk_in);
    #2 rst = 1'b0;
    @(negedge clk_in);

    // Zero period acts as stop; restart of an idle channel does nothing
    issue(2'd3, CMD_ONESHOT, PW'(0), c);
    issue(2'd1, CMD_PERIOD, PW'(0), c);
    issue(2'd0, CMD_RESTART, PW'(0), c);
    @(negedge clk_in);
    check("zero_period_active", 32'(active), 32'(0));
    wait_until(cyc + 50);
    check("zero_period_still_idle", 32'(active), 32'(0));
    check("final_queue_empty", 32'(exp_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
